// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   - RISC-V load/store funct3 encodings (F3_B/F3_H/F3_W/F3_BU/F3_HU)
//   - FSM state enum (IDLE, ISSUE, READ, RESP)
//   - requester port ID type
package dmem_arb_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

endpackage

// File: rtl/dmem_access_check.sv
// dmem_access_check: combinational legality check for one load/store command.
// Ports:
//   we      in  1 = store, 0 = load
//   funct3  in  RISC-V load/store funct3
//   addr_lo in  byte address bits [1:0]
//   legal   out 1 when funct3 is valid for the direction and the access is aligned
module dmem_access_check
  import dmem_arb_pkg::*;
(
  input  logic       we,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic       legal
);

  always_comb begin
    // NOTE: default assignment first so every path drives legal; no latch is inferred.
    legal = 1'b0;
    case (funct3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = !addr_lo[0];
      F3_W:    legal = (addr_lo == 2'b00);
      F3_BU:   legal = !we;                    // unsigned forms exist only for loads
      F3_HU:   legal = !we && !addr_lo[0];
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-cycle core's Data_Memory between the core
// load/store port (p0) and a debug/DMA loader port (p1). The winning command is
// latched in IDLE, checked for legality, then sequenced ISSUE -> (READ -> RESP).
// Configuration macro: DMEM_ARB_RR_EN -- defined: round-robin on ties;
// undefined: fixed priority to port 0 and no pointer register.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   pX_req/we/funct3/addr/wdata        requester command (held until gnt)
//   pX_gnt / pX_err / pX_rvalid        accept pulse, reject pulse, read-data pulse
//   rdata                              load result shared by both ports
//   mem_read, mem_write, alu_result,
//   rs2_data, instruction              Data_Memory controls (funct3 in [14:12])
//   data_mem_data                      Data_Memory read data (already extended)
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [2:0]        p0_funct3,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [2:0]        p1_funct3,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p0_err,
  output logic              p0_rvalid,
  output logic              p1_gnt,
  output logic              p1_err,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] alu_result,
  output logic [DATA_W-1:0] rs2_data,
  output logic [31:0]       instruction,
  input  logic [DATA_W-1:0] data_mem_data
);

  state_t   state, state_nxt;
  port_id_t sel_port;
  logic     any_req, sel_we, sel_legal, take;
  logic [2:0]        sel_funct3;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Latched command
  port_id_t          cmd_port;
  logic              cmd_we, cmd_legal;
  logic [2:0]        cmd_funct3;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  assign any_req = p0_req || p1_req;
  assign take    = (state == IDLE) && any_req;

`ifdef DMEM_ARB_RR_EN
  // rr_ptr names the port that wins the next tie.
  port_id_t rr_ptr;

  always_comb begin
    if (p0_req && p1_req) sel_port = rr_ptr;
    else if (p0_req)      sel_port = PORT0;
    else                  sel_port = PORT1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_ptr <= PORT0;
    else if (take) rr_ptr <= (sel_port == PORT0) ? PORT1 : PORT0;
  end
`else
  assign sel_port = p0_req ? PORT0 : PORT1;
`endif

  assign sel_we     = (sel_port == PORT1) ? p1_we     : p0_we;
  assign sel_funct3 = (sel_port == PORT1) ? p1_funct3 : p0_funct3;
  assign sel_addr   = (sel_port == PORT1) ? p1_addr   : p0_addr;
  assign sel_wdata  = (sel_port == PORT1) ? p1_wdata  : p0_wdata;

  dmem_access_check u_check (
    .we      (sel_we),
    .funct3  (sel_funct3),
    .addr_lo (sel_addr[1:0]),
    .legal   (sel_legal)
  );

  // Command register: only written in IDLE, so requester changes while an
  // access is in flight cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) begin
      cmd_port   <= PORT0;
      cmd_we     <= 1'b0;
      cmd_legal  <= 1'b0;
      cmd_funct3 <= 3'b000;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else if (take) begin
      cmd_port   <= sel_port;
      cmd_we     <= sel_we;
      cmd_legal  <= sel_legal;
      cmd_funct3 <= sel_funct3;
      cmd_addr   <= sel_addr;
      cmd_wdata  <= sel_wdata;
    end
  end

  // Load data is captured at the closing edge of READ and held until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rdata <= '0;
    else if (state == READ)    rdata <= data_mem_data;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = (cmd_legal && !cmd_we) ? READ : IDLE;
      READ:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs, decoded only from registered state and the latched command.
  always_comb begin
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    p0_err    = 1'b0;
    p1_err    = 1'b0;
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      ISSUE: begin
        p0_gnt    = (cmd_port == PORT0);
        p1_gnt    = (cmd_port == PORT1);
        p0_err    = (cmd_port == PORT0) && !cmd_legal;
        p1_err    = (cmd_port == PORT1) && !cmd_legal;
        mem_write = cmd_legal && cmd_we;
        mem_read  = cmd_legal && !cmd_we;
      end
      READ: mem_read = 1'b1;
      RESP: begin
        p0_rvalid = (cmd_port == PORT0);
        p1_rvalid = (cmd_port == PORT1);
      end
      default: ;
    endcase
  end

  assign alu_result  = cmd_addr;
  assign rs2_data    = cmd_wdata;
  assign instruction = {17'd0, cmd_funct3, 12'd0};

endmodule
